// File: rtl/lif_pkg.sv
// Shared helpers for the LIF datapath: saturation limits, saturating add and
// shift-parameter clamping, used by the synapse driver and the neuron array.
package lif_pkg;

    function automatic logic signed [63:0] max_pos(input int w);
        return (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [63:0] min_neg(input int w);
        return -(64'sd1 <<< (w - 1));
    endfunction

    // Keeps a decay shift inside 1..w-1 so a bad parameter can never zero or wrap the shifter
    function automatic int clamp_shift(input int s, input int w);
        if (s < 1) begin
            return 1;
        end
        if (s > w - 1) begin
            return w - 1;
        end
        return s;
    endfunction

    function automatic logic signed [63:0] sat_add(
        input logic signed [63:0] a,
        input logic signed [63:0] b,
        input int                 w
    );
        logic signed [63:0] sum;
        sum = a + b;
        if (sum > max_pos(w)) begin
            return max_pos(w);
        end
        if (sum < min_neg(w)) begin
            return min_neg(w);
        end
        return sum;
    endfunction

endpackage

// File: rtl/lif_synapse_driver_rr_arbiter.sv
// Round-robin arbiter: one grant per cycle, search begins at the internal
// pointer, which advances past the winner and holds when nothing is requested.
module rr_arbiter #(
    parameter int N = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         i_req,
    output logic [N-1:0]         o_grant,
    output logic [$clog2(N)-1:0] o_grant_idx
);

    localparam int IW = $clog2(N);

    logic [IW-1:0] r_ptr;
    logic          w_found;
    int            w_cand;
    logic [IW-1:0] w_candIdx;

    always_comb begin
        o_grant     = '0;
        o_grant_idx = '0;
        w_found     = 1'b0;
        w_cand      = 0;
        w_candIdx   = '0;
        for (int off = 0; off < N; off++) begin
            w_cand = int'(r_ptr) + off;
            if (w_cand >= N) begin
                w_cand = w_cand - N;
            end
            w_candIdx = w_cand[IW-1:0];
            if (!w_found && i_req[w_candIdx]) begin
                w_found              = 1'b1;
                o_grant[w_candIdx]   = 1'b1;
                o_grant_idx          = w_candIdx;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (w_found) begin
            if (int'(o_grant_idx) == N - 1) begin
                r_ptr <= '0;
            end else begin
                r_ptr <= o_grant_idx + 1'b1;
            end
        end
    end

endmodule

// File: rtl/lif_synapse_driver.sv
// Presynaptic front end: latches spikes, serializes them round-robin and folds
// each granted weight into a leaky, saturating synaptic-current register.
module lif_synapse_driver
    import lif_pkg::*;
#(
    parameter int WIDTH        = 16,
    parameter int N_IN         = 8,
    parameter int TAU_SHIFT    = 3,
    parameter int DECAY_PERIOD = 4,
    parameter int CNT_W        = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_IN-1:0]            i_spike_in,
    input  logic                       i_w_we,
    input  logic [$clog2(N_IN)-1:0]    i_w_addr,
    input  logic signed [WIDTH-1:0]    i_w_data,
    output logic signed [WIDTH-1:0]    o_I_out,
    output logic                       o_busy,
    output logic [CNT_W-1:0]           o_drop_count
);

    localparam int AW  = $clog2(N_IN);
    localparam int TS  = clamp_shift(TAU_SHIFT, WIDTH);
    localparam int DCW = (DECAY_PERIOD > 1) ? $clog2(DECAY_PERIOD) : 1;

    logic [N_IN-1:0]         r_pend;
    logic [DCW-1:0]          r_dc;
    logic signed [WIDTH-1:0] r_weight [N_IN];
    logic signed [WIDTH-1:0] r_current;
    logic [CNT_W-1:0]        r_dropCount;

    logic [N_IN-1:0]         w_grant;
    logic [AW-1:0]           w_grantIdx;
    logic                    w_anyGrant;
    logic                    w_tick;
    logic                    w_drop;
    logic signed [WIDTH-1:0] w_grantWeight;
    logic signed [WIDTH+1:0] w_curExt;
    logic signed [WIDTH+1:0] w_decay;
    logic signed [WIDTH+1:0] w_base;
    logic signed [WIDTH+1:0] w_addTerm;
    logic signed [WIDTH-1:0] w_next;

    rr_arbiter #(
        .N(N_IN)
    ) u_arbiter (
        .clk        (clk),
        .rst        (rst),
        .i_req      (r_pend),
        .o_grant    (w_grant),
        .o_grant_idx(w_grantIdx)
    );

    assign w_anyGrant   = |w_grant;
    assign w_tick       = (int'(r_dc) == DECAY_PERIOD - 1);
    assign w_drop       = |(i_spike_in & r_pend & ~w_grant);
    assign o_busy       = |r_pend;
    assign o_I_out      = r_current;
    assign o_drop_count = r_dropCount;

    // Decay is taken from the pre-add value so a tick and a grant in the same cycle compose
    always_comb begin
        w_grantWeight = r_weight[w_grantIdx];
        w_curExt      = {{2{r_current[WIDTH-1]}}, r_current};
        w_decay       = w_tick ? (w_curExt >>> TS) : '0;
        w_base        = w_curExt - w_decay;
        w_addTerm     = w_anyGrant ? {{2{w_grantWeight[WIDTH-1]}}, w_grantWeight} : '0;
        w_next        = WIDTH'(sat_add({{(62-WIDTH){w_base[WIDTH+1]}}, w_base},
                                       {{(62-WIDTH){w_addTerm[WIDTH+1]}}, w_addTerm},
                                       WIDTH));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend      <= '0;
            r_dc        <= '0;
            r_current   <= '0;
            r_dropCount <= '0;
        end else begin
            r_pend    <= (r_pend & ~w_grant) | i_spike_in;
            r_dc      <= w_tick ? '0 : r_dc + 1'b1;
            r_current <= w_next;
            if (w_drop && (r_dropCount != {CNT_W{1'b1}})) begin
                r_dropCount <= r_dropCount + 1'b1;
            end
        end
    end

    // A write landing on the index being granted only takes effect for later grants
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_IN; i++) begin
                r_weight[i] <= '0;
            end
        end else if (i_w_we && (int'(i_w_addr) < N_IN)) begin
            r_weight[i_w_addr] <= i_w_data;
        end
    end

endmodule

// File: tb/tb_lif_synapse_driver.sv
// Directed bench for lif_synapse_driver: a slow-decay instance for the
// arithmetic/arbitration cases and a fast-decay instance for the leak case.
module tb_lif_synapse_driver;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [7:0]         spikeIn = '0;
    logic               wWe = 1'b0;
    logic [2:0]         wAddr = '0;
    logic signed [15:0] wData = '0;

    logic signed [15:0] iOut;
    logic               busy;
    logic [7:0]         dropCount;
    logic signed [15:0] iOutD;
    logic               busyD;
    logic [7:0]         dropCountD;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] spike;
        int         expI;
        logic       expBusy;
    } vec_t;

    vec_t vecs [12];

    always #5 clk = ~clk;

    lif_synapse_driver #(
        .WIDTH(16), .N_IN(8), .TAU_SHIFT(3), .DECAY_PERIOD(256), .CNT_W(8)
    ) dut (
        .clk(clk), .rst(rst), .i_spike_in(spikeIn), .i_w_we(wWe),
        .i_w_addr(wAddr), .i_w_data(wData),
        .o_I_out(iOut), .o_busy(busy), .o_drop_count(dropCount)
    );

    lif_synapse_driver #(
        .WIDTH(16), .N_IN(8), .TAU_SHIFT(3), .DECAY_PERIOD(4), .CNT_W(8)
    ) dutDecay (
        .clk(clk), .rst(rst), .i_spike_in(spikeIn), .i_w_we(wWe),
        .i_w_addr(wAddr), .i_w_data(wData),
        .o_I_out(iOutD), .o_busy(busyD), .o_drop_count(dropCountD)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    // One edge with the given inputs, then inputs return to idle
    task automatic applyStimulus(input logic [7:0] spike, input logic we,
                                 input logic [2:0] addr, input logic signed [15:0] data);
        spikeIn = spike;
        wWe     = we;
        wAddr   = addr;
        wData   = data;
        step();
        spikeIn = '0;
        wWe     = 1'b0;
        wAddr   = '0;
        wData   = '0;
    endtask

    task automatic writeWeight(input logic [2:0] addr, input logic signed [15:0] data);
        applyStimulus(8'h00, 1'b1, addr, data);
    endtask

    task automatic checkOutput(input string name, input logic signed [31:0] actual,
                               input logic signed [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, want %0d", name, actual, expected);
        end
    endtask

    task automatic applyReset();
        rst     = 1'b1;
        spikeIn = '0;
        wWe     = 1'b0;
        wAddr   = '0;
        wData   = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0]  = '{8'hFF, 0,  1'b1};
        vecs[1]  = '{8'h00, 1,  1'b1};
        vecs[2]  = '{8'h00, 3,  1'b1};
        vecs[3]  = '{8'h00, 6,  1'b1};
        vecs[4]  = '{8'h00, 10, 1'b1};
        vecs[5]  = '{8'h00, 15, 1'b1};
        vecs[6]  = '{8'h00, 21, 1'b1};
        vecs[7]  = '{8'h00, 28, 1'b1};
        vecs[8]  = '{8'h00, 36, 1'b0};
        vecs[9]  = '{8'h03, 36, 1'b1};
        vecs[10] = '{8'h00, 37, 1'b1};
        vecs[11] = '{8'h00, 39, 1'b0};

        $display("[TB] reset state");
        applyReset();
        checkOutput("reset I_out", $signed(iOut), 0);
        checkOutput("reset busy", busy, 0);
        checkOutput("reset drop_count", dropCount, 0);

        $display("[TB] single spike and decay");
        writeWeight(3'd2, 16'sd100);
        applyStimulus(8'h04, 1'b0, '0, '0);
        checkOutput("latency I_out after E0", $signed(iOutD), 0);
        checkOutput("busy after E0", busyD, 1);
        step();
        checkOutput("decay I_out after E1", $signed(iOutD), 100);
        checkOutput("slow I_out after E1", $signed(iOut), 100);
        step();
        checkOutput("decay first tick", $signed(iOutD), 88);
        idle(3);
        checkOutput("decay between ticks", $signed(iOutD), 88);
        step();
        checkOutput("decay second tick", $signed(iOutD), 77);

        $display("[TB] round-robin fairness");
        applyReset();
        for (int i = 0; i < 8; i++) begin
            writeWeight(3'(i), 16'(i + 1));
        end
        for (int v = 0; v < 12; v++) begin
            applyStimulus(vecs[v].spike, 1'b0, '0, '0);
            checkOutput($sformatf("rr I_out step %0d", v), $signed(iOut), vecs[v].expI);
            checkOutput($sformatf("rr busy step %0d", v), busy, vecs[v].expBusy);
        end

        $display("[TB] positive saturation");
        applyReset();
        writeWeight(3'd0, 16'sd30000);
        writeWeight(3'd1, 16'sd30000);
        applyStimulus(8'h03, 1'b0, '0, '0);
        step();
        checkOutput("sat pos first", $signed(iOut), 30000);
        step();
        checkOutput("sat pos clip", $signed(iOut), 32767);

        $display("[TB] negative saturation");
        applyReset();
        writeWeight(3'd0, -16'sd30000);
        writeWeight(3'd1, -16'sd30000);
        applyStimulus(8'h03, 1'b0, '0, '0);
        step();
        checkOutput("sat neg first", $signed(iOut), -30000);
        step();
        checkOutput("sat neg clip", $signed(iOut), -32768);

        $display("[TB] drop behaviour");
        applyReset();
        for (int i = 0; i < 8; i++) begin
            writeWeight(3'(i), 16'(i + 1));
        end
        applyStimulus(8'hFF, 1'b0, '0, '0);
        applyStimulus(8'h00, 1'b0, '0, '0);
        applyStimulus(8'h80, 1'b0, '0, '0);
        checkOutput("drop counted", dropCount, 1);
        idle(6);
        checkOutput("drop W7 once", $signed(iOut), 36);
        checkOutput("drop busy clear", busy, 0);
        applyStimulus(8'h01, 1'b0, '0, '0);
        applyStimulus(8'h01, 1'b0, '0, '0);
        checkOutput("regrant no drop", dropCount, 1);
        checkOutput("regrant first add", $signed(iOut), 37);
        checkOutput("regrant still busy", busy, 1);
        step();
        checkOutput("regrant second add", $signed(iOut), 38);
        checkOutput("regrant busy clear", busy, 0);

        $display("[TB] write/grant collision");
        applyReset();
        writeWeight(3'd3, 16'sd10);
        applyStimulus(8'h08, 1'b0, '0, '0);
        applyStimulus(8'h00, 1'b1, 3'd3, 16'sd50);
        checkOutput("collision old weight", $signed(iOut), 10);
        applyStimulus(8'h08, 1'b0, '0, '0);
        step();
        checkOutput("collision new weight", $signed(iOut), 60);

        $display("[TB] reset mid-operation");
        applyReset();
        writeWeight(3'd0, 16'sd500);
        applyStimulus(8'h01, 1'b0, '0, '0);
        applyStimulus(8'h03, 1'b0, '0, '0);
        applyStimulus(8'h01, 1'b0, '0, '0);
        checkOutput("pre-reset I_out", $signed(iOut), 500);
        checkOutput("pre-reset busy", busy, 1);
        checkOutput("pre-reset drop", dropCount, 1);
        #3;
        rst = 1'b1;
        #1;
        checkOutput("async reset I_out", $signed(iOut), 0);
        checkOutput("async reset busy", busy, 0);
        checkOutput("async reset drop", dropCount, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        applyStimulus(8'hFF, 1'b0, '0, '0);
        idle(10);
        checkOutput("post-reset weights cleared", $signed(iOut), 0);
        checkOutput("post-reset busy", busy, 0);
        checkOutput("post-reset drop", dropCount, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
